// File: rtl/mc_controller_if.sv
// mc_controller_if: control bundle between the multicycle controller and
// its datapath/UART. master = controller side, slave = datapath side.
interface mc_controller_if;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        zero;
    logic        pcen;
    logic        irwrite;
    logic        regwrite;
    logic        pcbufwrite;
    logic        iord;
    logic        memwrite;
    logic [1:0]  alusrca;
    logic [1:0]  alusrcb;
    logic [2:0]  regsrc;
    logic [1:0]  pcsrc;
    logic [4:0]  alucontrol;
    logic        rx_valid;
    logic        rx_ready;
    logic        tx_valid;
    logic        tx_ready;
    logic        halted;
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;

    modport master (
        input  op, funct3, funct7, zero, rx_valid, tx_ready,
        output pcen, irwrite, regwrite, pcbufwrite, iord, memwrite,
        output alusrca, alusrcb, regsrc, pcsrc, alucontrol,
        output rx_ready, tx_valid, halted, cycle_cnt, instret_cnt
    );

    modport slave (
        output op, funct3, funct7, zero, rx_valid, tx_ready,
        input  pcen, irwrite, regwrite, pcbufwrite, iord, memwrite,
        input  alusrca, alusrcb, regsrc, pcsrc, alucontrol,
        input  rx_ready, tx_valid, halted, cycle_cnt, instret_cnt
    );
endinterface

// File: rtl/mc_controller.sv
// mc_controller: Moore FSM for the multicycle RV32I datapath with UART IN/OUT.
// Define CTRL_PERF_EN to build the cycle/instret performance counters.
module mc_controller (
    input logic             clk,
    input logic             rstn,
    mc_controller_if.master bus
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IN     = 7'b0001011;
    localparam logic [6:0] OP_OUT    = 7'b0101011;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;

    typedef enum logic [4:0] {
        S_FETCH, S_DECODE, S_LUIWB, S_AUIPC, S_EXR, S_EXI,
        S_ALUWB, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_BR,
        S_JAL, S_JALR, S_INW, S_OUTW, S_HALT
    } state_t;

    state_t     state, next;
    logic       pcen_r, irwrite_r, regwrite_r, pcbufwrite_r;
    logic       memwrite_r, rx_ready_r, tx_valid_r;
    logic       taken, bad_br;
    logic [4:0] alu_r_op, alu_i_op, alu_b_op;

    function automatic logic [4:0] alu_dec(input logic [2:0] f3, input logic alt);
        logic [4:0] r;
        unique case (f3)
            3'b000:  r = alt ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    // ALU function and branch outcome decoded from the held instruction fields
    always_comb begin
        alu_r_op = alu_dec(bus.funct3, bus.funct7[5]);
        alu_i_op = alu_dec(bus.funct3, bus.funct7[5] && (bus.funct3 == 3'b101));
        alu_b_op = bus.funct3[2] ? (bus.funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        bad_br   = (bus.funct3[2:1] == 2'b01);
        taken    = ((bus.funct3 == 3'b000) || (bus.funct3 == 3'b101) ||
                    (bus.funct3 == 3'b111)) ? bus.zero : !bus.zero;
    end

    // state register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_FETCH;
        else       state <= next;
    end

    // next-state and per-state control decode
    always_comb begin
        next           = state;
        pcen_r         = 1'b0;
        irwrite_r      = 1'b0;
        regwrite_r     = 1'b0;
        pcbufwrite_r   = 1'b0;
        memwrite_r     = 1'b0;
        rx_ready_r     = 1'b0;
        tx_valid_r     = 1'b0;
        bus.iord       = 1'b0;
        bus.alusrca    = 2'd0;
        bus.alusrcb    = 2'd0;
        bus.regsrc     = 3'd0;
        bus.pcsrc      = 2'd0;
        bus.alucontrol = ALU_ADD;
        unique case (state)
            S_FETCH: begin
                irwrite_r    = 1'b1;
                pcbufwrite_r = 1'b1;
                pcen_r       = 1'b1;
                bus.alusrcb  = 2'd1;
                next         = S_DECODE;
            end
            S_DECODE: begin
                bus.alusrca = 2'd1;
                bus.alusrcb = 2'd2;
                unique case (1'b1)
                    (bus.op == OP_LUI):    next = S_LUIWB;
                    (bus.op == OP_AUIPC):  next = S_AUIPC;
                    (bus.op == OP_OP):     next = S_EXR;
                    (bus.op == OP_OPIMM):  next = S_EXI;
                    (bus.op == OP_LOAD):   next = S_MEMADR;
                    (bus.op == OP_STORE):  next = S_MEMADR;
                    (bus.op == OP_BRANCH): next = S_BR;
                    (bus.op == OP_JAL):    next = S_JAL;
                    (bus.op == OP_JALR):   next = S_JALR;
                    (bus.op == OP_IN):     next = S_INW;
                    (bus.op == OP_OUT):    next = S_OUTW;
                    default:               next = S_HALT;
                endcase
            end
            S_LUIWB: begin
                bus.regsrc = 3'd2;
                regwrite_r = 1'b1;
                next       = S_FETCH;
            end
            S_AUIPC: begin
                bus.alusrca = 2'd1;
                bus.alusrcb = 2'd2;
                next        = S_ALUWB;
            end
            S_EXR: begin
                bus.alusrca    = 2'd2;
                bus.alucontrol = alu_r_op;
                next           = S_ALUWB;
            end
            S_EXI: begin
                bus.alusrca    = 2'd2;
                bus.alusrcb    = 2'd2;
                bus.alucontrol = alu_i_op;
                next           = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_r = 1'b1;
                next       = S_FETCH;
            end
            S_MEMADR: begin
                bus.alusrca = 2'd2;
                bus.alusrcb = 2'd2;
                next        = (bus.op == OP_STORE) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.iord = 1'b1;
                next     = S_MEMWB;
            end
            // address held so the data register sees a stable read word
            S_MEMWB: begin
                bus.iord   = 1'b1;
                bus.regsrc = 3'd1;
                regwrite_r = 1'b1;
                next       = S_FETCH;
            end
            S_MEMWR: begin
                bus.iord   = 1'b1;
                memwrite_r = 1'b1;
                next       = S_FETCH;
            end
            S_BR: begin
                bus.alusrca    = 2'd2;
                bus.alucontrol = alu_b_op;
                bus.pcsrc      = 2'd1;
                pcen_r         = taken && !bad_br;
                next           = bad_br ? S_HALT : S_FETCH;
            end
            S_JAL: begin
                bus.regsrc = 3'd3;
                regwrite_r = 1'b1;
                bus.pcsrc  = 2'd1;
                pcen_r     = 1'b1;
                next       = S_FETCH;
            end
            S_JALR: begin
                bus.alusrca = 2'd2;
                bus.alusrcb = 2'd2;
                bus.pcsrc   = 2'd2;
                pcen_r      = 1'b1;
                bus.regsrc  = 3'd3;
                regwrite_r  = 1'b1;
                next        = S_FETCH;
            end
            S_INW: begin
                bus.regsrc = 3'd4;
                rx_ready_r = 1'b1;
                regwrite_r = bus.rx_valid;
                next       = bus.rx_valid ? S_FETCH : S_INW;
            end
            S_OUTW: begin
                tx_valid_r = 1'b1;
                next       = bus.tx_ready ? S_FETCH : S_OUTW;
            end
            default: next = S_HALT;
        endcase
    end

    assign bus.pcen       = pcen_r & rstn;
    assign bus.irwrite    = irwrite_r & rstn;
    assign bus.regwrite   = regwrite_r & rstn;
    assign bus.pcbufwrite = pcbufwrite_r & rstn;
    assign bus.memwrite   = memwrite_r & rstn;
    assign bus.rx_ready   = rx_ready_r & rstn;
    assign bus.tx_valid   = tx_valid_r & rstn;
    assign bus.halted     = (state == S_HALT);

`ifdef CTRL_PERF_EN
    logic [31:0] cyc_q, ret_q;

    // free-running cycle count and retired-instruction count
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc_q <= 32'd0;
            ret_q <= 32'd0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (next == S_FETCH) ret_q <= ret_q + 32'd1;
        end
    end

    assign bus.cycle_cnt   = cyc_q;
    assign bus.instret_cnt = ret_q;
`else
    assign bus.cycle_cnt   = 32'd0;
    assign bus.instret_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: per-instruction observation of mc_controller checked
// against a latency/effect model derived from instruction classes.
module tb_mc_controller;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   done_n = 0;
    int   ref_cyc = 0;

    mc_controller_if bus();

    mc_controller dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) ref_cyc <= 0;
        else       ref_cyc <= ref_cyc + 1;
    end

    typedef struct packed {
        int lat;
        int rw;
        int rsrc;
        int mw;
        int pc;
        int io;
        int alu;
        int tx;
        int rx;
        int cons;
        int hlt;
    } obs_t;

    localparam int C_LUI = 0, C_AUIPC = 1, C_OP = 2, C_OPI = 3, C_LD = 4;
    localparam int C_ST = 5, C_BR = 6, C_JAL = 7, C_JALR = 8, C_IN = 9;
    localparam int C_OUT = 10;

    logic [6:0] opc [11] = '{7'b0110111, 7'b0010111, 7'b0110011, 7'b0010011,
                             7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
                             7'b1100111, 7'b0001011, 7'b0101011};

    function automatic int alu_code(logic [2:0] f3, logic alt);
        int base [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        if (alt && f3 == 3'd0) return 1;
        if (alt && f3 == 3'd5) return 7;
        return base[f3];
    endfunction

    function automatic obs_t model(int cls, logic [2:0] f3, logic [6:0] f7,
                                   logic z, int rxw, int txw);
        obs_t e;
        logic tk;
        e = '0;
        e.rsrc = -1;
        e.alu = -1;
        e.pc = 1;
        case (cls)
            C_LUI:   begin e.lat = 3; e.rw = 1; e.rsrc = 2; end
            C_AUIPC: begin e.lat = 4; e.rw = 1; e.rsrc = 0; end
            C_OP:    begin e.lat = 4; e.rw = 1; e.rsrc = 0; e.alu = alu_code(f3, f7[5]); end
            C_OPI:   begin e.lat = 4; e.rw = 1; e.rsrc = 0;
                           e.alu = alu_code(f3, f7[5] && f3 == 3'd5); end
            C_LD:    begin e.lat = 5; e.rw = 1; e.rsrc = 1; e.io = 2; e.alu = 0; end
            C_ST:    begin e.lat = 4; e.mw = 1; e.io = 1; e.alu = 0; end
            C_BR: begin
                e.lat = 3;
                e.alu = f3[2] ? (f3[1] ? 4 : 3) : 1;
                if (f3 == 3'd0)      tk = z;
                else if (f3 == 3'd1) tk = !z;
                else                 tk = f3[0] ? z : !z;
                e.pc = tk ? 2 : 1;
            end
            C_JAL:   begin e.lat = 3; e.rw = 1; e.rsrc = 3; e.pc = 2; end
            C_JALR:  begin e.lat = 3; e.rw = 1; e.rsrc = 3; e.pc = 2; e.alu = 0; end
            C_IN:    begin e.lat = 3 + rxw; e.rw = 1; e.rsrc = 4; e.rx = rxw + 1; e.cons = 1; end
            default: begin e.lat = 3 + txw; e.tx = txw + 1; end
        endcase
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        bus.op = 7'd0;
        bus.funct3 = 3'd0;
        bus.funct7 = 7'd0;
        bus.zero = 1'b0;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        done_n = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
    endtask

    // runs one instruction starting in the fetch cycle; ends at the next fetch
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
                             input logic [6:0] f7, input logic z,
                             input int rxw, input int txw, output obs_t r);
        int rxc = 0;
        int txc = 0;
        r = '0;
        r.rsrc = -1;
        r.alu = -1;
        r.lat = -1;
        bus.op = o;
        bus.funct3 = f3;
        bus.funct7 = f7;
        bus.zero = z;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc > 1) begin
                @(negedge clk);
                bus.rx_valid = bus.rx_ready && (rxc >= rxw);
                if (bus.rx_ready) rxc++;
                bus.tx_ready = bus.tx_valid && (txc >= txw);
                if (bus.tx_valid) txc++;
                #1;
                if (bus.irwrite) begin
                    r.lat = cyc - 1;
                    done_n++;
                    break;
                end
                if (bus.halted) begin
                    r.hlt = 1;
                    r.lat = cyc;
                    break;
                end
            end
            if (bus.pcen) r.pc++;
            if (bus.regwrite) begin
                r.rw++;
                r.rsrc = int'(bus.regsrc);
            end
            if (bus.memwrite) r.mw++;
            if (bus.iord) r.io++;
            if (bus.alusrca == 2'd2) r.alu = int'(bus.alucontrol);
            if (bus.tx_valid) r.tx++;
            if (bus.rx_ready) r.rx++;
            if (bus.rx_ready && bus.rx_valid) r.cons++;
        end
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if ({bus.pcen, bus.irwrite, bus.regwrite, bus.pcbufwrite, bus.memwrite,
             bus.rx_ready, bus.tx_valid, bus.halted} !== 8'd0) begin
            errors++;
            $display("FAIL reset_strobes got=%b want=0", {bus.pcen, bus.irwrite,
                     bus.regwrite, bus.pcbufwrite, bus.memwrite, bus.rx_ready,
                     bus.tx_valid, bus.halted});
        end
        do_reset();
        checks++;
        if (bus.irwrite !== 1'b1 || bus.pcen !== 1'b1 || bus.alusrcb !== 2'd1) begin
            errors++;
            $display("FAIL reset_fetch got irwrite=%b pcen=%b srcb=%0d want 1 1 1",
                     bus.irwrite, bus.pcen, bus.alusrcb);
        end
        checks++;
        if (bus.cycle_cnt !== 32'd0 || bus.instret_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters got %0d %0d want 0 0",
                     bus.cycle_cnt, bus.instret_cnt);
        end
    endtask

    task automatic test_alu();
        obs_t r;
        do_reset();
        run_instr(opc[C_OP], 3'd0, 7'b0100000, 1'b0, 0, 0, r);
        checks++;
        if (r.lat !== 4 || r.alu !== 1 || r.rw !== 1 || r.rsrc !== 0) begin
            errors++;
            $display("FAIL sub got lat=%0d alu=%0d rw=%0d rsrc=%0d want 4 1 1 0",
                     r.lat, r.alu, r.rw, r.rsrc);
        end
        run_instr(opc[C_OP], 3'd5, 7'b0100000, 1'b0, 0, 0, r);
        checks++;
        if (r.alu !== 7) begin
            errors++;
            $display("FAIL sra got alu=%0d want 7", r.alu);
        end
        run_instr(opc[C_OPI], 3'd0, 7'b0100000, 1'b0, 0, 0, r);
        checks++;
        if (r.alu !== 0 || r.lat !== 4) begin
            errors++;
            $display("FAIL addi_nosub got alu=%0d lat=%0d want 0 4", r.alu, r.lat);
        end
        run_instr(opc[C_OPI], 3'd5, 7'b0100000, 1'b0, 0, 0, r);
        checks++;
        if (r.alu !== 7) begin
            errors++;
            $display("FAIL srai got alu=%0d want 7", r.alu);
        end
    endtask

    task automatic test_mem();
        obs_t r;
        do_reset();
        run_instr(opc[C_LD], 3'd2, 7'd0, 1'b0, 0, 0, r);
        checks++;
        if (r.lat !== 5 || r.io !== 2 || r.rsrc !== 1 || r.rw !== 1 || r.mw !== 0) begin
            errors++;
            $display("FAIL load got lat=%0d io=%0d rsrc=%0d rw=%0d mw=%0d want 5 2 1 1 0",
                     r.lat, r.io, r.rsrc, r.rw, r.mw);
        end
        run_instr(opc[C_ST], 3'd2, 7'd0, 1'b0, 0, 0, r);
        checks++;
        if (r.lat !== 4 || r.mw !== 1 || r.io !== 1 || r.rw !== 0) begin
            errors++;
            $display("FAIL store got lat=%0d mw=%0d io=%0d rw=%0d want 4 1 1 0",
                     r.lat, r.mw, r.io, r.rw);
        end
    endtask

    task automatic test_branch();
        obs_t r;
        do_reset();
        run_instr(opc[C_BR], 3'd0, 7'd0, 1'b1, 0, 0, r);
        checks++;
        if (r.lat !== 3 || r.pc !== 2) begin
            errors++;
            $display("FAIL beq_taken got lat=%0d pcen=%0d want 3 2", r.lat, r.pc);
        end
        run_instr(opc[C_BR], 3'd1, 7'd0, 1'b1, 0, 0, r);
        checks++;
        if (r.lat !== 3 || r.pc !== 1) begin
            errors++;
            $display("FAIL bne_not_taken got lat=%0d pcen=%0d want 3 1", r.lat, r.pc);
        end
        run_instr(opc[C_JALR], 3'd0, 7'd0, 1'b0, 0, 0, r);
        checks++;
        if (r.lat !== 3 || r.pc !== 2 || r.rsrc !== 3 || r.rw !== 1) begin
            errors++;
            $display("FAIL jalr got lat=%0d pcen=%0d rsrc=%0d rw=%0d want 3 2 3 1",
                     r.lat, r.pc, r.rsrc, r.rw);
        end
    endtask

    task automatic test_uart();
        obs_t r;
        do_reset();
        run_instr(opc[C_OUT], 3'd0, 7'd0, 1'b0, 0, 5, r);
        checks++;
        if (r.tx !== 6 || r.lat !== 8 || r.rw !== 0) begin
            errors++;
            $display("FAIL out_stall got tx=%0d lat=%0d rw=%0d want 6 8 0",
                     r.tx, r.lat, r.rw);
        end
        run_instr(opc[C_IN], 3'd0, 7'd0, 1'b0, 1, 0, r);
        checks++;
        if (r.lat !== 4 || r.rw !== 1 || r.rsrc !== 4 || r.cons !== 1 || r.rx !== 2) begin
            errors++;
            $display("FAIL in_wait got lat=%0d rw=%0d rsrc=%0d cons=%0d rx=%0d want 4 1 4 1 2",
                     r.lat, r.rw, r.rsrc, r.cons, r.rx);
        end
    endtask

    task automatic test_halt();
        obs_t r;
        do_reset();
        run_instr(7'b1111111, 3'd0, 7'd0, 1'b0, 0, 0, r);
        checks++;
        if (r.hlt !== 1 || r.lat !== 3 || r.rw !== 0 || r.mw !== 0) begin
            errors++;
            $display("FAIL illegal_halt got hlt=%0d lat=%0d rw=%0d mw=%0d want 1 3 0 0",
                     r.hlt, r.lat, r.rw, r.mw);
        end
        bus.rx_valid = 1'b1;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({bus.pcen, bus.irwrite, bus.regwrite, bus.pcbufwrite, bus.memwrite,
                 bus.rx_ready, bus.tx_valid, bus.halted} !== 8'd1) begin
                errors++;
                $display("FAIL halt_hold[%0d] got=%b want=00000001", i,
                         {bus.pcen, bus.irwrite, bus.regwrite, bus.pcbufwrite,
                          bus.memwrite, bus.rx_ready, bus.tx_valid, bus.halted});
            end
        end
        do_reset();
        checks++;
        if (bus.halted !== 1'b0 || bus.irwrite !== 1'b1) begin
            errors++;
            $display("FAIL halt_exit got halted=%b irwrite=%b want 0 1",
                     bus.halted, bus.irwrite);
        end
        run_instr(opc[C_BR], 3'd2, 7'd0, 1'b0, 0, 0, r);
        checks++;
        if (r.hlt !== 1 || r.lat !== 4 || r.pc !== 1) begin
            errors++;
            $display("FAIL bad_branch got hlt=%0d lat=%0d pcen=%0d want 1 4 1",
                     r.hlt, r.lat, r.pc);
        end
    endtask

    task automatic test_reset_abort();
        bit seen = 0;
        do_reset();
        bus.op = opc[C_ST];
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (bus.memwrite) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL abort_reach got memwrite=0 want 1 within 8 cycles");
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (bus.memwrite !== 1'b0 || bus.regwrite !== 1'b0 || bus.pcen !== 1'b0) begin
            errors++;
            $display("FAIL abort_drop got mw=%b rw=%b pcen=%b want 0 0 0",
                     bus.memwrite, bus.regwrite, bus.pcen);
        end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++;
        if (bus.irwrite !== 1'b1 || bus.memwrite !== 1'b0) begin
            errors++;
            $display("FAIL abort_fetch got irwrite=%b mw=%b want 1 0",
                     bus.irwrite, bus.memwrite);
        end
    endtask

    task automatic test_back_to_back();
        obs_t r, e;
        int cls, rxw, txw;
        logic [2:0] f3;
        logic [6:0] f7;
        logic z;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            cls = $urandom_range(0, 10);
            f3 = 3'($urandom_range(0, 7));
            if (cls == C_BR && f3[2:1] == 2'b01) f3[2] = 1'b1;
            f7 = 7'($urandom_range(0, 127));
            z = 1'($urandom_range(0, 1));
            rxw = $urandom_range(0, 3);
            txw = $urandom_range(0, 3);
            e = model(cls, f3, f7, z, rxw, txw);
            run_instr(opc[cls], f3, f7, z, rxw, txw, r);
            checks++;
            if (r !== e) begin
                errors++;
                $display("FAIL random[%0d] cls=%0d f3=%0d got=%h want=%h",
                         n, cls, f3, r, e);
            end
        end
    endtask

    task automatic test_perf();
        obs_t r;
        do_reset();
        for (int i = 0; i < 3; i++)
            run_instr(opc[C_OPI], 3'd0, 7'd0, 1'b0, 0, 0, r);
        run_instr(7'b1111111, 3'd0, 7'd0, 1'b0, 0, 0, r);
        repeat (3) @(negedge clk);
        #1;
`ifdef CTRL_PERF_EN
        checks++;
        if (bus.instret_cnt !== 32'(done_n) || done_n != 3) begin
            errors++;
            $display("FAIL perf_instret got %0d want 3", bus.instret_cnt);
        end
        checks++;
        if (bus.cycle_cnt !== 32'(ref_cyc)) begin
            errors++;
            $display("FAIL perf_cycle got %0d want %0d", bus.cycle_cnt, ref_cyc);
        end
`else
        checks++;
        if (bus.instret_cnt !== 32'd0 || bus.cycle_cnt !== 32'd0) begin
            errors++;
            $display("FAIL perf_off got %0d %0d want 0 0",
                     bus.instret_cnt, bus.cycle_cnt);
        end
`endif
    endtask

    initial begin
        bus.op = 7'd0;
        bus.funct3 = 3'd0;
        bus.funct7 = 7'd0;
        bus.zero = 1'b0;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_uart();
        test_halt();
        test_reset_abort();
        test_back_to_back();
        test_perf();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
